// File: rtl/seven_pkg.sv
// Shared constants and types for the seven-segment receive path.
// Segment patterns are active-high with bit0=a ... bit6=g.
package seven_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } out_state_t;

endpackage

// File: rtl/seven_reader_if.sv
// Frame output channel of the seven-segment reader: valid/ready plus
// per-digit nibble, blank and illegal-pattern flags.
interface seven_reader_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                    out_valid;
    logic                    out_ready;
    logic [4*NUM_DIGITS-1:0] out_digits;
    logic [NUM_DIGITS-1:0]   out_blank;
    logic [NUM_DIGITS-1:0]   out_err;

    modport master (
        output out_valid,
        output out_digits,
        output out_blank,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digits,
        input  out_blank,
        input  out_err,
        output out_ready
    );

endinterface

// File: rtl/seg_to_hex.sv
// Combinational seven-segment pattern decoder: legal glyphs map to a nibble,
// an all-dark pattern is a blank, everything else is flagged as illegal.
module seg_to_hex
    import seven_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             blank,
    output logic             err
);

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_reader.sv
// Receive side of a multiplexed seven-segment bus: synchronise, filter,
// decode each digit and hand complete frames out on a valid/ready channel.
//
// state   | meaning
// COLLECT | no frame on the output; waiting for the working mask to fill
// PRESENT | frame held on the output until the consumer takes it
module seven_reader
    import seven_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEG_W-1:0]      seg_in,
    input  logic [NUM_DIGITS-1:0] dig_en,
    seven_reader_if.master        frame,
    output logic                  overrun
);

    localparam int              CNT_W   = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CNT - 1);

    logic [SEG_W-1:0]      seg_m, s_seg, p_seg;
    logic [NUM_DIGITS-1:0] en_m, s_en, p_en;
    logic [CNT_W-1:0]      cnt;
    logic                  lock;
    logic                  en_onehot, stable, capture;

    logic [3:0]            dec_nib;
    logic                  dec_blank, dec_err;

    logic [NUM_DIGITS-1:0]       mask, mask_nxt, cap_bit;
    logic [NUM_DIGITS-1:0][3:0]  w_nib, n_nib;
    logic [NUM_DIGITS-1:0]       w_blank, n_blank, w_err, n_err;
    logic                        frame_done;

    out_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '0;
            s_seg <= '0;
            p_seg <= '0;
            en_m  <= '0;
            s_en  <= '0;
            p_en  <= '0;
        end else begin
            seg_m <= seg_in;
            s_seg <= seg_m;
            p_seg <= s_seg;
            en_m  <= dig_en;
            s_en  <= en_m;
            p_en  <= s_en;
        end
    end

    assign en_onehot = (s_en != '0) && ((s_en & (s_en - NUM_DIGITS'(1))) == '0);
    assign stable    = en_onehot && (s_seg == p_seg) && (s_en == p_en);
    assign capture   = stable && !lock && (cnt == CNT_CAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            lock <= 1'b0;
        end else if (!stable) begin
            cnt  <= '0;
            lock <= 1'b0;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                lock <= 1'b1;
            end
        end
    end

    seg_to_hex u_dec (
        .seg    (s_seg),
        .nibble (dec_nib),
        .blank  (dec_blank),
        .err    (dec_err)
    );

    // s_en is one-hot whenever capture is high, so it doubles as the slot select.
    always_comb begin
        cap_bit  = capture ? s_en : '0;
        mask_nxt = mask | cap_bit;
        frame_done = &mask_nxt;
        n_nib    = w_nib;
        n_blank  = w_blank;
        n_err    = w_err;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_bit[i]) begin
                n_nib[i]   = dec_nib;
                n_blank[i] = dec_blank;
                n_err[i]   = dec_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask    <= '0;
            w_nib   <= '0;
            w_blank <= '0;
            w_err   <= '0;
        end else begin
            mask    <= frame_done ? '0 : mask_nxt;
            w_nib   <= n_nib;
            w_blank <= n_blank;
            w_err   <= n_err;
        end
    end

    // Frames are loaded from the next-slot values so a frame whose last digit
    // is captured this cycle is presented without an extra cycle of delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= COLLECT;
            frame.out_valid  <= 1'b0;
            frame.out_digits <= '0;
            frame.out_blank  <= '0;
            frame.out_err    <= '0;
            overrun          <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (frame_done) begin
                        frame.out_digits <= n_nib;
                        frame.out_blank  <= n_blank;
                        frame.out_err    <= n_err;
                        frame.out_valid  <= 1'b1;
                        state            <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (frame.out_ready) begin
                        if (frame_done) begin
                            frame.out_digits <= n_nib;
                            frame.out_blank  <= n_blank;
                            frame.out_err    <= n_err;
                        end else begin
                            frame.out_valid <= 1'b0;
                            state           <= COLLECT;
                        end
                    end else if (frame_done) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    frame.out_valid <= 1'b0;
                    state           <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_reader.sv
// Bench for seven_reader: a 4-digit build for frame behaviour and a 1-digit
// build for capture latency, checked against a lookup-table reference model.
module tb_seven_reader;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int DWELL = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [6:0]   seg4;
    logic [N-1:0] en4;
    logic         ovr4;
    seven_reader_if #(.NUM_DIGITS(N)) if4 ();
    seven_reader #(.NUM_DIGITS(N), .STABLE_CNT(S)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_in  (seg4),
        .dig_en  (en4),
        .frame   (if4),
        .overrun (ovr4)
    );

    logic [6:0] seg1;
    logic [0:0] en1;
    logic       ovr1;
    seven_reader_if #(.NUM_DIGITS(1)) if1 ();
    seven_reader #(.NUM_DIGITS(1), .STABLE_CNT(S)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_in  (seg1),
        .dig_en  (en1),
        .frame   (if1),
        .overrun (ovr1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  e;
    } frame_t;

    typedef struct {
        logic [3:0][6:0] pats;
        logic [15:0]     d;
        logic [3:0]      b;
        logic [3:0]      e;
    } vec_t;

    frame_t fq[$];
    vec_t   vt[4];

    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference decode: position in the glyph table is the nibble.
    function automatic logic [5:0] ref_decode(logic [6:0] p);
        if (p == 7'h00) return 6'b10_0000;
        for (int k = 0; k < 16; k++) begin
            if (pat_tab[k] == p) return {2'b00, 4'(k)};
        end
        return 6'b01_0000;
    endfunction

    function automatic frame_t ref_frame(logic [3:0][6:0] p);
        frame_t     f;
        logic [5:0] r;
        f = '0;
        for (int d = 0; d < N; d++) begin
            r = ref_decode(p[d]);
            f.d[4*d +: 4] = r[3:0];
            f.b[d] = r[5];
            f.e[d] = r[4];
        end
        return f;
    endfunction

    function automatic logic [6:0] rand_pat();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6) return pat_tab[$urandom_range(0, 15)];
        if (r < 8) return 7'h00;
        return 7'($urandom_range(0, 127));
    endfunction

    always @(negedge clk) begin
        if (rst_n && if4.out_valid && if4.out_ready)
            fq.push_back({if4.out_digits, if4.out_blank, if4.out_err});
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seg4  = '0;
        en4   = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
        fq.delete();
    endtask

    task automatic dwell(int d, logic [6:0] p, int n);
        seg4 = p;
        en4  = N'(1 << d);
        step(n);
    endtask

    task automatic scan(logic [3:0][6:0] p);
        for (int d = 0; d < N; d++) dwell(d, p[d], DWELL);
    endtask

    task automatic check_frames(string nm, int n_exp, frame_t ex);
        check({nm, "_count"}, fq.size(), n_exp);
        if (fq.size() > 0) begin
            check({nm, "_digits"}, fq[$].d, ex.d);
            check({nm, "_blank"},  fq[$].b, ex.b);
            check({nm, "_err"},    fq[$].e, ex.e);
        end
    endtask

    initial begin
        int              rise;
        logic [3:0][6:0] rp;
        frame_t          ex;

        vt[0] = '{pats: {7'h71, 7'h7C, 7'h4F, 7'h06}, d: 16'hFB31, b: 4'b0000, e: 4'b0000};
        vt[1] = '{pats: {7'h6F, 7'h00, 7'h12, 7'h3F}, d: 16'h9000, b: 4'b0100, e: 4'b0010};
        vt[2] = '{pats: {7'h79, 7'h5E, 7'h39, 7'h77}, d: 16'hEDCA, b: 4'b0000, e: 4'b0000};
        vt[3] = '{pats: {7'h66, 7'h7F, 7'h07, 7'h7D}, d: 16'h4876, b: 4'b0000, e: 4'b0000};

        rst_n = 1'b0;
        seg4 = '0;
        en4 = '0;
        seg1 = '0;
        en1 = '0;
        if4.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        #3;
        check("rst_valid4", if4.out_valid, 0);
        check("rst_digits4", if4.out_digits, 0);
        check("rst_blank4", if4.out_blank, 0);
        check("rst_err4", if4.out_err, 0);
        check("rst_ovr4", ovr4, 0);
        check("rst_valid1", if1.out_valid, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Single-digit build: capture latency from a pin change.
        seg1 = 7'h5B;
        en1  = 1'b1;
        rise = -1;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            if (if1.out_valid && rise < 0) rise = c;
        end
        check("lat_rise", rise, 2 + S + 1);
        check("lat_digit", if1.out_digits, 4'h2);
        check("lat_blank", if1.out_blank, 0);
        check("lat_err", if1.out_err, 0);
        if1.out_ready = 1'b1;
        step(1);
        check("lat_drop", if1.out_valid, 0);
        check("lat_ovr", ovr1, 0);

        // Table-driven frames with the consumer always ready.
        do_reset();
        if4.out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            fq.delete();
            scan(vt[v].pats);
            check_frames($sformatf("vec%0d", v), 1, '{d: vt[v].d, b: vt[v].b, e: vt[v].e});
        end

        // Glitching digit 0 never settles long enough to be captured.
        do_reset();
        if4.out_ready = 1'b1;
        en4 = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            seg4 = (k % 2 == 1) ? 7'h5B : 7'h06;
            step(S - 1);
        end
        check("glitch_valid", if4.out_valid, 0);
        dwell(1, 7'h66, DWELL);
        dwell(2, 7'h6D, DWELL);
        dwell(3, 7'h07, DWELL);
        check("glitch_nocap", fq.size(), 0);
        dwell(0, 7'h3F, 24);
        check_frames("glitch_once", 1, '{d: 16'h7540, b: 4'b0000, e: 4'b0000});
        dwell(1, 7'h66, DWELL);
        dwell(2, 7'h6D, DWELL);
        dwell(3, 7'h07, DWELL);
        check("glitch_norecap", fq.size(), 1);

        // Consumer stalls across two scans: first frame held, second dropped.
        do_reset();
        if4.out_ready = 1'b0;
        scan(vt[0].pats);
        check("ovr_valid1", if4.out_valid, 1);
        check("ovr_digits1", if4.out_digits, 16'hFB31);
        check("ovr_flag1", ovr4, 0);
        scan(vt[2].pats);
        check("ovr_valid2", if4.out_valid, 1);
        check("ovr_digits2", if4.out_digits, 16'hFB31);
        check("ovr_flag2", ovr4, 1);
        if4.out_ready = 1'b1;
        step(1);
        if4.out_ready = 1'b0;
        check("ovr_drop", if4.out_valid, 0);
        check("ovr_sticky", ovr4, 1);

        // Reset in the middle of a scan discards the partial frame.
        do_reset();
        if4.out_ready = 1'b0;
        scan(vt[1].pats);
        scan(vt[0].pats);
        check("mid_pre_ovr", ovr4, 1);
        dwell(0, vt[3].pats[0], DWELL);
        dwell(1, vt[3].pats[1], DWELL);
        dwell(2, vt[3].pats[2], 4);
        rst_n = 1'b0;
        #2;
        check("mid_valid", if4.out_valid, 0);
        check("mid_digits", if4.out_digits, 0);
        check("mid_blank", if4.out_blank, 0);
        check("mid_err", if4.out_err, 0);
        check("mid_ovr", ovr4, 0);
        rst_n = 1'b1;
        step(1);
        if4.out_ready = 1'b1;
        fq.delete();
        dwell(2, vt[3].pats[2], DWELL);
        dwell(3, vt[3].pats[3], DWELL);
        check("mid_partial", fq.size(), 0);
        dwell(0, vt[3].pats[0], DWELL);
        dwell(1, vt[3].pats[1], DWELL);
        check_frames("mid_full", 1, ref_frame(vt[3].pats));

        // Random patterns against the lookup-table model.
        do_reset();
        if4.out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            for (int d = 0; d < N; d++) rp[d] = rand_pat();
            ex = ref_frame(rp);
            fq.delete();
            scan(rp);
            check_frames($sformatf("rnd%0d", t), 1, ex);
        end
        check("rnd_ovr", ovr4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
